e_md_iter: RTL and testbench
============================

# e_md_iter

Parametrised iterative multiply/divide unit for the E stage of the pipelined MIPS core. It holds the HI/LO register pair and executes mult/multu/div/divu with a shift-add multiplier and a restoring divider. Multiply speed is configurable, and an optional multiply-accumulate feature can be compiled in. `Busy` and `Start` feed the D-stage stall logic, and `E_RDHI`/`E_RDLO` feed mfhi/mflo forwarding.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits; must be even and ≥ 8.
- `MUL_BITS`, default 1: multiplier bits retired per multiply iteration; one of 1, 2, 4; must divide `WIDTH`.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `E_MDControl`  in  4  op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi, 7 madd, 8 maddu; 9–15 none.
- `E_D1`  in  WIDTH  rs operand (multiplicand / dividend / mt source).
- `E_D2`  in  WIDTH  rt operand (multiplier / divisor).
- `Start`  out  1  combinational: op ∈ {1,2,3,4} (plus {7,8} with accumulate enabled) and `Busy`=0.
- `Busy`  out  1  registered: state ≠ IDLE; reset 0.
- `E_RDHI`  out  WIDTH  HI register; reset 0.
- `E_RDLO`  out  WIDTH  LO register; reset 0.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - A start-class op is accepted on the edge where `Start`=1 and `reset`=0.
  - Operands are latched as magnitudes, with sign flags for signed ops; unsigned ops take flags 0.
  - Counter loads `WIDTH/MUL_BITS` and state goes to MUL, or loads `WIDTH` and goes to DIV.
- MUL:
  - Each edge adds `MUL_BITS` partial products into a 2·`WIDTH` accumulator and shifts; counter decrements.
  - When the counter reaches 0 the state goes to FIX.
- DIV:
  - Each edge performs one restoring step on the (`WIDTH`+1)-bit partial remainder; counter decrements.
  - When the counter reaches 0 the state goes to FIX.
- FIX: a single edge applies sign correction, writes HI/LO, and returns to IDLE.
  - Product: negated if sign flags differ; HI = upper half, LO = lower half.
  - Quotient: negated if sign flags differ; written to LO.
  - Remainder: takes the sign of the dividend; written to HI.
- Divisor zero (div and divu): LO = all ones, HI = `E_D1` as latched; no sign correction.
- Signed overflow, MIN ÷ −1: LO = MIN, HI = 0.
- mtlo/mthi in IDLE: the register is written from `E_D1` on the next edge.
- mtlo/mthi and start-class ops while `Busy`=1 are ignored. The stall logic must prevent this; it is not an error.
- HI/LO never change while `Busy`=1; mfhi/mflo see old values until the FIX edge.
- Reset has priority in any state:
  - Next edge: state IDLE, counter 0, HI = LO = 0, `Busy`=0.
  - An in-flight operation is discarded.

## Timing
- Accept edge = cycle 0. `Busy` is high in cycles 1 through N+1.
  - Multiply: N = `WIDTH/MUL_BITS`.
  - Divide: N = `WIDTH`.
- HI/LO hold the new values from cycle N+2 on; that is also the first cycle a new op can be accepted.
- Back-to-back accept at cycle N+2 is permitted.
- `Start` is high only in the accept cycle (one cycle per op).
- mt writes have latency 1 and never assert `Busy`.
- Defaults (`WIDTH`=32): mult busy 33 cycles; with `MUL_BITS`=4, busy 9 cycles; div busy 33 cycles.

## Configuration
- `MD_ACCUM_EN` defined:
  - Ops 7 (madd, signed) and 8 (maddu) are start-class with multiply timing.
  - The FIX state adds the corrected 2·`WIDTH` product to {HI,LO}, modulo 2^(2·`WIDTH`).
- `MD_ACCUM_EN` undefined: ops 7 and 8 behave as none; `Start` stays 0 and state is unchanged.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF:
  - `Start`=1 for exactly one cycle; `Busy`=1 for exactly 33 cycles.
  - Then HI=0xFFFFFFFE, LO=0x00000001.
  - With `MUL_BITS`=4: same result, `Busy` for 9 cycles.
- mult −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- div:
  - −7 ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu 0xFFFFFFFF ÷ 0x10 → LO=0x0FFFFFFF, HI=0xF.
- divu 5 ÷ 0 and div −5 ÷ 0 → LO=0xFFFFFFFF, HI=E_D1 (5 / 0xFFFFFFFB), `Busy` 33 cycles.
- Busy interactions:
  - Start div, issue mthi 0x1234 at busy cycle 3 → HI is the remainder, not 0x1234.
  - Start div, assert `reset` at busy cycle 10 → next cycle `Busy`=0, HI=LO=0.
  - After that reset, mtlo 7 → LO=7 one cycle later.
- Accumulate, with `MD_ACCUM_EN`:
  - mthi 0, mtlo 0xFFFFFFFF, maddu 1×1 → HI=1, LO=0.
  - madd −1×1 from HI=LO=0 → HI=LO=0xFFFFFFFF.
  - Without the macro, op 7 → `Start`=0, HI/LO unchanged.

Source files
------------

// File: rtl/e_md_iter.sv
// rtl/e_md_iter.sv - iterative mult/div unit holding HI/LO for the E stage
// Optional multiply-accumulate (madd/maddu) is compiled in with MD_ACCUM_EN.
module e_md_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       E_MDControl,
    input  logic [WIDTH-1:0] E_D1,
    input  logic [WIDTH-1:0] E_D2,
    output logic             Start,
    output logic             Busy,
    output logic [WIDTH-1:0] E_RDHI,
    output logic [WIDTH-1:0] E_RDLO
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int MW = WIDTH + MUL_BITS;
    localparam logic [CW-1:0] MUL_ITER = CW'(WIDTH / MUL_BITS);
    localparam logic [CW-1:0] DIV_ITER = CW'(WIDTH);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
`ifdef MD_ACCUM_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa;
    logic [2*WIDTH-1:0] prod;
    logic               sgn_a;
    logic               sgn_b;
    logic               is_div;
    logic               div_zero;
    logic               acc_r;

    logic               op_mul;
    logic               op_div;
    logic               op_acc;
    logic               op_signed;
    logic               neg1;
    logic               neg2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;

    always_comb begin
        op_mul    = (E_MDControl == OP_MULT) || (E_MDControl == OP_MULTU);
        op_div    = (E_MDControl == OP_DIV) || (E_MDControl == OP_DIVU);
        op_signed = (E_MDControl == OP_MULT) || (E_MDControl == OP_DIV);
`ifdef MD_ACCUM_EN
        op_acc    = (E_MDControl == OP_MADD) || (E_MDControl == OP_MADDU);
        op_signed = op_signed || (E_MDControl == OP_MADD);
`else
        op_acc    = 1'b0;
`endif
    end

    assign Busy  = (state != IDLE);
    assign Start = (op_mul || op_div || op_acc) && !Busy;

    assign neg1 = op_signed && E_D1[WIDTH-1];
    assign neg2 = op_signed && E_D2[WIDTH-1];
    assign mag1 = neg1 ? -E_D1 : E_D1;
    assign mag2 = neg2 ? -E_D2 : E_D2;

    // Shift-add step: prod holds {running upper half, unretired multiplier bits}
    logic [MW-1:0]      partial;
    logic [MW-1:0]      mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (prod[i]) begin
                partial = partial + (MW'(opa) << i);
            end
        end
        mul_sum  = MW'(prod[2*WIDTH-1:WIDTH]) + partial;
        mul_next = {mul_sum, prod[WIDTH-1:MUL_BITS]};
    end

    // Restoring step: prod holds {partial remainder, dividend/quotient bits}
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opa});
        div_sub   = div_shift[WIDTH-1:0] - opa;
        div_next  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), prod[WIDTH-2:0], div_ge};
    end

    // Divide-by-zero leaves quotient all ones and remainder = |dividend|, so
    // the usual remainder sign fix reproduces E_D1; only the quotient fix is skipped.
    logic [2*WIDTH-1:0] prod_fix;
    logic [2*WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_fix = (sgn_a ^ sgn_b) ? -prod : prod;
        acc_sum  = {E_RDHI, E_RDLO} + prod_fix;
        quo_fix  = ((sgn_a ^ sgn_b) && !div_zero) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        rem_fix  = sgn_a ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            opa      <= '0;
            prod     <= '0;
            sgn_a    <= 1'b0;
            sgn_b    <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            acc_r    <= 1'b0;
            E_RDHI   <= '0;
            E_RDLO   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_mul || op_acc) begin
                        opa      <= mag1;
                        prod     <= {{WIDTH{1'b0}}, mag2};
                        sgn_a    <= neg1;
                        sgn_b    <= neg2;
                        is_div   <= 1'b0;
                        div_zero <= 1'b0;
                        acc_r    <= op_acc;
                        cnt      <= MUL_ITER;
                        state    <= MUL;
                    end else if (op_div) begin
                        opa      <= mag2;
                        prod     <= {{WIDTH{1'b0}}, mag1};
                        sgn_a    <= neg1;
                        sgn_b    <= neg2;
                        is_div   <= 1'b1;
                        div_zero <= (E_D2 == '0);
                        acc_r    <= 1'b0;
                        cnt      <= DIV_ITER;
                        state    <= DIV;
                    end else if (E_MDControl == OP_MTLO) begin
                        E_RDLO <= E_D1;
                    end else if (E_MDControl == OP_MTHI) begin
                        E_RDHI <= E_D1;
                    end
                end
                MUL: begin
                    prod <= mul_next;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                DIV: begin
                    prod <= div_next;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        E_RDLO <= quo_fix;
                        E_RDHI <= rem_fix;
                    end else if (acc_r) begin
                        {E_RDHI, E_RDLO} <= acc_sum;
                    end else begin
                        {E_RDHI, E_RDLO} <= prod_fix;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_e_md_iter.sv
// tb/tb_e_md_iter.sv - directed self-checking bench for e_md_iter
module tb_e_md_iter;
    logic        clk;
    logic        reset;
    logic [3:0]  md_op, md_op4;
    logic [31:0] d1, d2, d1_4, d2_4;
    logic        start, busy, start4, busy4;
    logic [31:0] rdhi, rdlo, rdhi4, rdlo4;
    int          checks;
    int          failures;

    e_md_iter #(.WIDTH(32), .MUL_BITS(1)) dut (
        .clk(clk), .reset(reset), .E_MDControl(md_op), .E_D1(d1), .E_D2(d2),
        .Start(start), .Busy(busy), .E_RDHI(rdhi), .E_RDLO(rdlo)
    );

    e_md_iter #(.WIDTH(32), .MUL_BITS(4)) dut4 (
        .clk(clk), .reset(reset), .E_MDControl(md_op4), .E_D1(d1_4), .E_D2(d2_4),
        .Start(start4), .Busy(busy4), .E_RDHI(rdhi4), .E_RDLO(rdlo4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Holds the op for the whole busy window (it must be ignored), counting Start and Busy cycles.
    task automatic run_op(input bit sel, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int starts, output int busy_n);
        starts = 0;
        busy_n = 0;
        @(negedge clk);
        if (sel) begin md_op4 = op; d1_4 = a; d2_4 = b; end
        else begin md_op = op; d1 = a; d2 = b; end
        #1;
        if ((sel ? start4 : start) === 1'b1) starts++;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if ((sel ? busy4 : busy) !== 1'b1) break;
            busy_n++;
            if ((sel ? start4 : start) === 1'b1) starts++;
        end
        if (sel) md_op4 = 4'd0; else md_op = 4'd0;
    endtask

    task automatic do_mt(input logic [3:0] op, input logic [31:0] val);
        @(negedge clk);
        md_op = op;
        d1 = val;
        @(negedge clk);
        md_op = 4'd0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rdhi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", rdhi); end
        checks++; if (rdlo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", rdlo); end
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start); end
        reset = 1'b0;
    endtask

    task automatic test_multu;
        int s, b;
        run_op(1'b0, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, s, b);
        checks++; if (s != 1) begin failures++; $display("FAIL multu_start got=%0d exp=1", s); end
        checks++; if (b != 33) begin failures++; $display("FAIL multu_busy got=%0d exp=33", b); end
        checks++; if (rdhi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", rdhi); end
        checks++; if (rdlo !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", rdlo); end
    endtask

    task automatic test_mult;
        int s, b;
        run_op(1'b0, 4'd1, 32'hFFFFFFFD, 32'd5, s, b);
        checks++; if (rdhi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", rdhi); end
        checks++; if (rdlo !== 32'hFFFFFFF1) begin failures++; $display("FAIL mult_lo got=%h exp=fffffff1", rdlo); end
    endtask

    task automatic test_div;
        int s, b;
        run_op(1'b0, 4'd3, 32'hFFFFFFF9, 32'd2, s, b);
        checks++; if (b != 33) begin failures++; $display("FAIL div_busy got=%0d exp=33", b); end
        checks++; if (rdlo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_lo got=%h exp=fffffffd", rdlo); end
        checks++; if (rdhi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_hi got=%h exp=ffffffff", rdhi); end
        run_op(1'b0, 4'd3, 32'h80000000, 32'hFFFFFFFF, s, b);
        checks++; if (rdlo !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", rdlo); end
        checks++; if (rdhi !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=0", rdhi); end
        run_op(1'b0, 4'd4, 32'hFFFFFFFF, 32'h10, s, b);
        checks++; if (rdlo !== 32'h0FFFFFFF) begin failures++; $display("FAIL divu_lo got=%h exp=0fffffff", rdlo); end
        checks++; if (rdhi !== 32'hF) begin failures++; $display("FAIL divu_hi got=%h exp=f", rdhi); end
    endtask

    task automatic test_div_zero;
        int s, b;
        run_op(1'b0, 4'd4, 32'd5, 32'd0, s, b);
        checks++; if (b != 33) begin failures++; $display("FAIL divu0_busy got=%0d exp=33", b); end
        checks++; if (rdlo !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu0_lo got=%h exp=ffffffff", rdlo); end
        checks++; if (rdhi !== 32'd5) begin failures++; $display("FAIL divu0_hi got=%h exp=5", rdhi); end
        run_op(1'b0, 4'd3, 32'hFFFFFFFB, 32'd0, s, b);
        checks++; if (b != 33) begin failures++; $display("FAIL div0_busy got=%0d exp=33", b); end
        checks++; if (rdlo !== 32'hFFFFFFFF) begin failures++; $display("FAIL div0_lo got=%h exp=ffffffff", rdlo); end
        checks++; if (rdhi !== 32'hFFFFFFFB) begin failures++; $display("FAIL div0_hi got=%h exp=fffffffb", rdhi); end
    endtask

    task automatic test_back_to_back;
        int s, b;
        run_op(1'b0, 4'd2, 32'd6, 32'd7, s, b);
        checks++; if (rdlo !== 32'd42) begin failures++; $display("FAIL b2b_mul_lo got=%h exp=2a", rdlo); end
        md_op = 4'd4; d1 = 32'd100; d2 = 32'd7;
        #1;
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL b2b_start got=%b exp=1", start); end
        @(negedge clk);
        md_op = 4'd0;
        #1;
        b = 0;
        for (int i = 0; i < 200 && busy === 1'b1; i++) begin
            b++;
            @(negedge clk);
            #1;
        end
        checks++; if (b != 33) begin failures++; $display("FAIL b2b_busy got=%0d exp=33", b); end
        checks++; if (rdlo !== 32'd14) begin failures++; $display("FAIL b2b_div_lo got=%h exp=e", rdlo); end
        checks++; if (rdhi !== 32'd2) begin failures++; $display("FAIL b2b_div_hi got=%h exp=2", rdhi); end
    endtask

    task automatic test_busy_mt;
        @(negedge clk);
        md_op = 4'd3; d1 = 32'hFFFFFFF9; d2 = 32'd2;
        @(negedge clk);
        md_op = 4'd0;
        repeat (2) @(negedge clk);
        md_op = 4'd6; d1 = 32'h1234;
        @(negedge clk);
        md_op = 4'd0;
        #1;
        checks++; if (rdhi !== 32'd2) begin failures++; $display("FAIL busy_hold_hi got=%h exp=2", rdhi); end
        for (int i = 0; i < 200 && busy === 1'b1; i++) begin
            @(negedge clk);
            #1;
        end
        checks++; if (rdhi !== 32'hFFFFFFFF) begin failures++; $display("FAIL busy_mthi_hi got=%h exp=ffffffff", rdhi); end
        checks++; if (rdlo !== 32'hFFFFFFFD) begin failures++; $display("FAIL busy_mthi_lo got=%h exp=fffffffd", rdlo); end
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
        md_op = 4'd4; d1 = 32'd1000; d2 = 32'd3;
        @(negedge clk);
        md_op = 4'd0;
        repeat (9) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midop_busy got=%b exp=1", busy); end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midop_rst_busy got=%b exp=0", busy); end
        checks++; if (rdhi !== 32'h0) begin failures++; $display("FAIL midop_rst_hi got=%h exp=0", rdhi); end
        checks++; if (rdlo !== 32'h0) begin failures++; $display("FAIL midop_rst_lo got=%h exp=0", rdlo); end
        reset = 1'b0;
        md_op = 4'd5; d1 = 32'd7;
        #1;
        checks++; if (rdlo !== 32'h0) begin failures++; $display("FAIL mtlo_early got=%h exp=0", rdlo); end
        @(negedge clk);
        md_op = 4'd0;
        #1;
        checks++; if (rdlo !== 32'd7) begin failures++; $display("FAIL mtlo_lo got=%h exp=7", rdlo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mtlo_busy got=%b exp=0", busy); end
        for (int i = 0; i < 40; i++) @(negedge clk);
        #1;
        checks++; if (rdhi !== 32'h0) begin failures++; $display("FAIL discard_hi got=%h exp=0", rdhi); end
    endtask

    task automatic test_mul_bits4;
        int s, b;
        run_op(1'b1, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, s, b);
        checks++; if (s != 1) begin failures++; $display("FAIL mb4_start got=%0d exp=1", s); end
        checks++; if (b != 9) begin failures++; $display("FAIL mb4_busy got=%0d exp=9", b); end
        checks++; if (rdhi4 !== 32'hFFFFFFFE) begin failures++; $display("FAIL mb4_hi got=%h exp=fffffffe", rdhi4); end
        checks++; if (rdlo4 !== 32'h00000001) begin failures++; $display("FAIL mb4_lo got=%h exp=00000001", rdlo4); end
        run_op(1'b1, 4'd1, 32'hFFFFFFFD, 32'd5, s, b);
        checks++; if (rdhi4 !== 32'hFFFFFFFF) begin failures++; $display("FAIL mb4_mult_hi got=%h exp=ffffffff", rdhi4); end
        checks++; if (rdlo4 !== 32'hFFFFFFF1) begin failures++; $display("FAIL mb4_mult_lo got=%h exp=fffffff1", rdlo4); end
        run_op(1'b1, 4'd2, 32'h12345678, 32'h9ABCDEF0, s, b);
        checks++; if ({rdhi4, rdlo4} !== 64'h0B00EA4E_242D2080) begin failures++; $display("FAIL mb4_mix got=%h exp=0b00ea4e242d2080", {rdhi4, rdlo4}); end
    endtask

    task automatic test_accum;
`ifdef MD_ACCUM_EN
        int s, b;
        do_mt(4'd6, 32'h0);
        do_mt(4'd5, 32'hFFFFFFFF);
        run_op(1'b0, 4'd8, 32'd1, 32'd1, s, b);
        checks++; if (s != 1) begin failures++; $display("FAIL maddu_start got=%0d exp=1", s); end
        checks++; if (b != 33) begin failures++; $display("FAIL maddu_busy got=%0d exp=33", b); end
        checks++; if (rdhi !== 32'd1) begin failures++; $display("FAIL maddu_hi got=%h exp=1", rdhi); end
        checks++; if (rdlo !== 32'd0) begin failures++; $display("FAIL maddu_lo got=%h exp=0", rdlo); end
        do_mt(4'd6, 32'h0);
        do_mt(4'd5, 32'h0);
        run_op(1'b0, 4'd7, 32'hFFFFFFFF, 32'd1, s, b);
        checks++; if (rdhi !== 32'hFFFFFFFF) begin failures++; $display("FAIL madd_hi got=%h exp=ffffffff", rdhi); end
        checks++; if (rdlo !== 32'hFFFFFFFF) begin failures++; $display("FAIL madd_lo got=%h exp=ffffffff", rdlo); end
`else
        do_mt(4'd5, 32'h55);
        do_mt(4'd6, 32'hAA);
        @(negedge clk);
        md_op = 4'd7; d1 = 32'd3; d2 = 32'd4;
        #1;
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL noacc_start got=%b exp=0", start); end
        @(negedge clk);
        md_op = 4'd0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL noacc_busy got=%b exp=0", busy); end
        checks++; if (rdlo !== 32'h55) begin failures++; $display("FAIL noacc_lo got=%h exp=55", rdlo); end
        checks++; if (rdhi !== 32'hAA) begin failures++; $display("FAIL noacc_hi got=%h exp=aa", rdhi); end
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        md_op = 4'd0; d1 = 32'd0; d2 = 32'd0;
        md_op4 = 4'd0; d1_4 = 32'd0; d2_4 = 32'd0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_busy_mt();
        test_reset_midop();
        test_mul_bits4();
        test_accum();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
